button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Collects single-cycle press events from several front-panel buttons and delivers them, one at a time, to the processor control unit over a valid/ready handshake. Each raw button input is synchronized and edge-detected into a single-cycle press. The press is latched as pending, and pending channels are served in round-robin order. The block sits between the board push-buttons and the processor's command/step logic, so no press is lost while the consumer is busy.

## Interface
- N_BTN, 4: number of button channels; legal range 2..16.
- DEBOUNCE_CYCLES, 16: required stable-input length in cycles; used only when the debounce feature is compiled in.
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  reset, synchronous, active-low.
- Btn  input  N_BTN  raw, unsynchronized button levels; 1 = pressed.
- EvValid  output  1  an event is offered on EvId.
- EvReady  input  1  consumer accepts the offered event.
- EvId  output  $clog2(N_BTN)  index of the offered channel.
- Pending  output  N_BTN  per-channel latched, not-yet-delivered press.
- Overrun  output  N_BTN  sticky flag: a press arrived while that channel was already pending.
- ClrOverrun  input  N_BTN  per-bit clear for Overrun.

## Operation
- Per channel:
  - Btn passes through two flops (sync), then a rising-edge detector, producing a one-cycle Press.
  - A level held high yields exactly one Press.
- Pending[i]:
  - Set on Press[i].
  - Cleared when channel i is accepted (EvValid & EvReady & EvId==i).
  - Press[i] in the same cycle as acceptance of i: Pending[i] stays 1, so the new press is kept.
- Overrun[i]:
  - Set when Press[i] occurs while Pending[i]=1 and channel i is not being accepted that cycle.
  - Cleared by ClrOverrun[i].
  - Set and clear in the same cycle: set wins.
- State machine (enum state_t):
  - S_IDLE: EvValid=0. If any Pending bit is set, select the first pending channel searching upward from LastGrant+1 with wrap-around, register it into EvId, and go to S_OFFER.
  - S_OFFER: EvValid=1 and EvId held stable. On EvReady: clear that Pending bit, set LastGrant=EvId, and go to S_IDLE.
  - Illegal state: go to S_IDLE.
- Arbitration is fixed once an event is offered. A newly pending channel does not preempt an offered EvId.
- Reset (ResetN=0 at a rising edge) forces:
  - State=S_IDLE.
  - EvValid=0, EvId=0, Pending=0, Overrun=0.
  - Sync and edge flops=0.
  - LastGrant=N_BTN-1, so channel 0 has first priority.
- Reset asserted mid-offer drops the offered event; there is no partial handshake.
- A button held high through reset release produces one Press after release.

## Timing
- Btn high before edge 1:
  - Sync flops capture it at edges 1 and 2.
  - Pending set at edge 3.
  - EvValid high after edge 4.
- The handshake completes on the edge where EvValid & EvReady = 1. EvValid is low for the following cycle (S_IDLE), then high again after the next edge if any channel is pending.
  - Maximum throughput: one event per 2 cycles.
- EvReady asserted while EvValid=0 has no effect.
- All outputs are registered; there is no combinational path from EvReady to EvValid or EvId.

## Configuration
- BUTTON_ARB_DEBOUNCE_EN defined:
  - Each channel adds a counter after the sync flops.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Edge detection uses the debounced level.
  - Latency from Btn to Pending grows by DEBOUNCE_CYCLES.
  - Shorter glitches produce no Press.
- BUTTON_ARB_DEBOUNCE_EN undefined: no counter, and DEBOUNCE_CYCLES is ignored.

## Structure
- Package button_arb_pkg holds:
  - state_t enum (S_IDLE, S_OFFER).
  - Default N_BTN and DEBOUNCE_CYCLES constants.
  - Function for round-robin next-index selection.
- Sub-module btn_edge_sync holds the per-channel sync, optional debounce and edge detect; it is instantiated N_BTN times by generate.

## Test plan
- Reset with Btn=4'b0000, then Btn[2] high for 10 cycles with EvReady=1 → EvValid high after edge 4, EvId=2 for exactly 1 cycle, Pending=0 afterwards, one event total.
- Btn=4'b1011 pulsed together, EvReady=1 → EvIds in order 0,1,3, each EvValid 1 cycle separated by 1 idle cycle.
- EvReady=0 while channel 1 is offered, second press on Btn[1] → Overrun[1]=1, EvId stays 1; then EvReady=1 → one event; ClrOverrun[1] pulse → Overrun[1]=0.
- Press on channel 0 timed to coincide with acceptance of channel 0 → Pending[0] remains 1 and a second EvId=0 event follows.
- ResetN low during S_OFFER → next cycle EvValid=0, Pending=0, Overrun=0; after release, the held button gives one event.
- With BUTTON_ARB_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - A 10-cycle Btn glitch → no event.
  - A 20-cycle press → one event, EvValid high after edge 4+16.

Source files
------------

// File: rtl/button_arb_pkg.sv
// rtl/button_arb_pkg.sv - shared types, defaults and round-robin selector for button_event_arbiter
package button_arb_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    localparam int unsigned N_BTN_DEFAULT           = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int unsigned MAX_BTN                 = 16;

    // First set bit of pend searching upward from last+1, wrapping at n.
    function automatic int unsigned rr_next(
        input logic [MAX_BTN-1:0] pend,
        input int unsigned        last,
        input int unsigned        n
    );
        int unsigned sel;
        int unsigned idx;
        logic        found;
        sel   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_BTN; k++) begin
            idx = (last + k) % n;
            if (!found && (k <= n) && pend[idx[3:0]]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - per-button synchronizer, optional debounce (BUTTON_ARB_DEBOUNCE_EN), rising-edge press
module btn_edge_sync
    import button_arb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic press
);

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

`ifdef BUTTON_ARB_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] db_cnt;
    logic          db_level;

    // The debounced level follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync_q2 != db_level) begin
            if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync_q2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign level = db_level;
`else
    if (DEBOUNCE_CYCLES == 0) begin : g_debounce_len_ignored
    end

    assign level = sync_q2;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - latches button presses and offers them round-robin over valid/ready (debounce via BUTTON_ARB_DEBOUNCE_EN)
module button_event_arbiter
    import button_arb_pkg::*;
#(
    parameter  int unsigned N_BTN           = N_BTN_DEFAULT,
    parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    localparam int unsigned IDW             = $clog2(N_BTN)
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic [N_BTN-1:0] Btn,
    output logic             EvValid,
    input  logic             EvReady,
    output logic [IDW-1:0]   EvId,
    output logic [N_BTN-1:0] Pending,
    output logic [N_BTN-1:0] Overrun,
    input  logic [N_BTN-1:0] ClrOverrun
);

    state_t           state;
    state_t           state_next;
    logic             load_id;
    logic             grant_done;
    logic [IDW-1:0]   last_grant;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] accept_vec;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_edge_sync #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sync (
            .clk   (Clk),
            .resetn(ResetN),
            .btn   (Btn[i]),
            .press (press[i])
        );
    end

    always_comb begin
        state_next = state;
        load_id    = 1'b0;
        grant_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (|Pending) begin
                    state_next = S_OFFER;
                    load_id    = 1'b1;
                end
            end
            S_OFFER: begin
                if (EvReady) begin
                    state_next = S_IDLE;
                    grant_done = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        accept_vec = '0;
        if (grant_done) begin
            accept_vec[EvId] = 1'b1;
        end
    end

    // A press landing on the accept cycle re-arms Pending instead of counting as an overrun.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state      <= S_IDLE;
            EvId       <= '0;
            last_grant <= IDW'(N_BTN - 1);
            Pending    <= '0;
            Overrun    <= '0;
        end else begin
            state <= state_next;
            if (load_id) begin
                EvId <= IDW'(rr_next(MAX_BTN'(Pending), 32'(last_grant), N_BTN));
            end
            if (grant_done) begin
                last_grant <= EvId;
            end
            Pending <= (Pending & ~accept_vec) | press;
            Overrun <= (Overrun & ~ClrOverrun) | (press & Pending & ~accept_vec);
        end
    end

    assign EvValid = (state == S_OFFER);

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - self-checking bench for button_event_arbiter
module tb_button_event_arbiter;

    logic       Clk;
    logic       ResetN;
    logic [3:0] Btn;
    logic       EvValid;
    logic       EvReady;
    logic [1:0] EvId;
    logic [3:0] Pending;
    logic [3:0] Overrun;
    logic [3:0] ClrOverrun;

    int n_chk;
    int n_fail;

    typedef struct {
        logic       rstn;
        logic [3:0] btn;
        logic       rdy;
        logic [3:0] clr;
        logic       v;
        logic [1:0] id;
        logic [3:0] p;
        logic [3:0] o;
    } vec_t;

    vec_t vq[$];

    button_event_arbiter #(
        .N_BTN          (4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .Btn       (Btn),
        .EvValid   (EvValid),
        .EvReady   (EvReady),
        .EvId      (EvId),
        .Pending   (Pending),
        .Overrun   (Overrun),
        .ClrOverrun(ClrOverrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] b, input logic rd, input logic [3:0] c,
                       input logic v, input logic [1:0] id, input logic [3:0] p, input logic [3:0] o);
        vec_t e;
        e.rstn = r; e.btn = b; e.rdy = rd; e.clr = c;
        e.v = v; e.id = id; e.p = p; e.o = o;
        vq.push_back(e);
    endtask

    task automatic build_table();
        // reset
        add(0, 4'h0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(0, 4'h0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        // single button held 10 cycles
        add(1, 4'h4, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h4, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h4, 1, 4'h0, 0, 2'd0, 4'h4, 4'h0);
        add(1, 4'h4, 1, 4'h0, 1, 2'd2, 4'h4, 4'h0);
        for (int k = 0; k < 6; k++) add(1, 4'h4, 1, 4'h0, 0, 2'd2, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd2, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd2, 4'h0, 4'h0);
        // reset, then 1011 together: order 0,1,3
        add(0, 4'h0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(0, 4'h0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'hB, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd0, 4'hB, 4'h0);
        add(1, 4'h0, 1, 4'h0, 1, 2'd0, 4'hB, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd0, 4'hA, 4'h0);
        add(1, 4'h0, 1, 4'h0, 1, 2'd1, 4'hA, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd1, 4'h8, 4'h0);
        add(1, 4'h0, 1, 4'h0, 1, 2'd3, 4'h8, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd3, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd3, 4'h0, 4'h0);
        // stalled offer of channel 1, second press -> overrun, then accept and clear
        add(1, 4'h2, 0, 4'h0, 0, 2'd3, 4'h0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0, 2'd3, 4'h0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0, 2'd3, 4'h2, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1, 2'd1, 4'h2, 4'h0);
        add(1, 4'h2, 0, 4'h0, 1, 2'd1, 4'h2, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1, 2'd1, 4'h2, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1, 2'd1, 4'h2, 4'h2);
        add(1, 4'h0, 0, 4'h0, 1, 2'd1, 4'h2, 4'h2);
        add(1, 4'h0, 1, 4'h0, 0, 2'd1, 4'h0, 4'h2);
        add(1, 4'h0, 0, 4'h2, 0, 2'd1, 4'h0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0, 2'd1, 4'h0, 4'h0);
        // press on channel 0 coincident with its acceptance
        add(1, 4'h1, 1, 4'h0, 0, 2'd1, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd1, 4'h0, 4'h0);
        add(1, 4'h1, 1, 4'h0, 0, 2'd1, 4'h1, 4'h0);
        add(1, 4'h0, 1, 4'h0, 1, 2'd0, 4'h1, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd0, 4'h1, 4'h0);
        add(1, 4'h0, 1, 4'h0, 1, 2'd0, 4'h1, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        // reset during offer with button held through release
        add(1, 4'h8, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h8, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h8, 0, 4'h0, 0, 2'd0, 4'h8, 4'h0);
        add(1, 4'h8, 0, 4'h0, 1, 2'd3, 4'h8, 4'h0);
        add(0, 4'h8, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h8, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h8, 1, 4'h0, 0, 2'd0, 4'h0, 4'h0);
        add(1, 4'h8, 1, 4'h0, 0, 2'd0, 4'h8, 4'h0);
        add(1, 4'h8, 1, 4'h0, 1, 2'd3, 4'h8, 4'h0);
        add(1, 4'h8, 1, 4'h0, 0, 2'd3, 4'h0, 4'h0);
        add(1, 4'h8, 1, 4'h0, 0, 2'd3, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd3, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0, 2'd3, 4'h0, 4'h0);
    endtask

    initial begin
        logic found;
        int   first;
        int   nev;
        int   seen;
        n_chk      = 0;
        n_fail     = 0;
        ResetN     = 1'b0;
        Btn        = '0;
        EvReady    = 1'b0;
        ClrOverrun = '0;
        found      = 1'b0;
        first      = 0;
        nev        = 0;
        seen       = 0;

`ifndef BUTTON_ARB_DEBOUNCE_EN
        build_table();
        for (int i = 0; i < vq.size(); i++) begin
            ResetN     = vq[i].rstn;
            Btn        = vq[i].btn;
            EvReady    = vq[i].rdy;
            ClrOverrun = vq[i].clr;
            step();
            chk($sformatf("vec%0d EvValid", i), 32'(EvValid), 32'(vq[i].v));
            chk($sformatf("vec%0d EvId", i),    32'(EvId),    32'(vq[i].id));
            chk($sformatf("vec%0d Pending", i), 32'(Pending), 32'(vq[i].p));
            chk($sformatf("vec%0d Overrun", i), 32'(Overrun), 32'(vq[i].o));
        end

        // an offered channel is not preempted by a newer pending press
        ResetN = 1'b1; EvReady = 1'b0; ClrOverrun = '0;
        Btn = 4'h4;
        step();
        Btn = 4'h0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (EvValid) found = 1'b1;
        end
        chk("preempt offer seen", 32'(found), 32'd1);
        chk("preempt first id", 32'(EvId), 32'd2);
        Btn = 4'h1;
        step();
        Btn = 4'h0;
        repeat (4) step();
        chk("preempt still valid", 32'(EvValid), 32'd1);
        chk("preempt id held", 32'(EvId), 32'd2);
        chk("preempt pending both", 32'(Pending), 32'h5);
        EvReady = 1'b1;
        step();
        chk("preempt idle gap", 32'(EvValid), 32'd0);
        chk("preempt pending after accept", 32'(Pending), 32'h1);
        step();
        chk("preempt second valid", 32'(EvValid), 32'd1);
        chk("preempt second id", 32'(EvId), 32'd0);
        step();
        chk("preempt pending drained", 32'(Pending), 32'h0);
        EvReady = 1'b0;
`else
        repeat (2) step();
        ResetN = 1'b1;
        step();
        Btn = 4'h1;
        repeat (10) step();
        Btn = 4'h0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (EvValid || Pending != 4'h0) seen++;
        end
        chk("glitch no event", 32'(seen), 32'd0);

        ResetN = 1'b0;
        repeat (2) step();
        ResetN = 1'b1;
        step();
        EvReady = 1'b1;
        Btn = 4'h1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 20) Btn = 4'h0;
            if (EvValid) begin
                if (first == 0) first = k;
                nev++;
            end
        end
        chk("debounce latency", 32'(first), 32'd20);
        chk("debounce one event", 32'(nev), 32'd1);
        chk("debounce pending clear", 32'(Pending), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
